// File: rtl/dec_addr_sequencer_if.sv
// rtl/dec_addr_sequencer_if.sv - control/status bundle between the dec4 address sequencer and its controller
interface dec_addr_sequencer_if;
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_addr;
    logic [3:0] A;
    logic       busy;
    logic       sample;
    logic       done;

    modport master (
        output start, stop, load, load_addr,
        input  A, busy, sample, done
    );

    modport slave (
        input  start, stop, load, load_addr,
        output A, busy, sample, done
    );
endinterface

// File: rtl/dec_addr_sequencer.sv
// rtl/dec_addr_sequencer.sv - dec4 select scanner with dwell, sample strobe and done pulse
// Optional wrap-around scanning is enabled by defining SEQ_CONTINUOUS_EN.
module dec_addr_sequencer #(
    parameter int         DWELL      = 3,
    parameter logic [3:0] FIRST_ADDR = 4'd0,
    parameter logic [3:0] LAST_ADDR  = 4'd15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dec_addr_sequencer_if.slave   seq
);
    localparam int              CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] dwell_cnt, cnt_nxt;
    logic [3:0]    addr, addr_nxt;
    logic          busy_q, sample_q, done_q;
    logic          busy_nxt, sample_nxt, done_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dwell_cnt <= '0;
            addr      <= FIRST_ADDR;
            busy_q    <= 1'b0;
            sample_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= cnt_nxt;
            addr      <= addr_nxt;
            busy_q    <= busy_nxt;
            sample_q  <= sample_nxt;
            done_q    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = dwell_cnt;
        addr_nxt  = addr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (seq.start && !seq.stop) begin
                    state_nxt = RUN;
                    addr_nxt  = FIRST_ADDR;
                    cnt_nxt   = '0;
                end else if (seq.load) begin
                    addr_nxt = seq.load_addr;
                end
            end
            RUN: begin
                if (seq.stop) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (dwell_cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (addr != LAST_ADDR) begin
                        addr_nxt = addr + 4'd1;
                    end else begin
                        done_nxt = 1'b1;
`ifdef SEQ_CONTINUOUS_EN
                        addr_nxt  = FIRST_ADDR;
`else
                        state_nxt = DONE;
`endif
                    end
                end else begin
                    cnt_nxt = dwell_cnt + CW'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        // Strobes are registered, so they are derived from the state being entered.
        busy_nxt   = (state_nxt == RUN);
        sample_nxt = (state_nxt == RUN) && (cnt_nxt == CNT_LAST);
    end

    assign seq.A      = addr;
    assign seq.busy   = busy_q;
    assign seq.sample = sample_q;
    assign seq.done   = done_q;
endmodule

// File: doc/dec_addr_sequencer.md
Name: dec_addr_sequencer

Overview:
- Upstream address generator for the 4x16 active-low decoder (dec4). Drives the decoder's 4-bit select input A.
- Scans A from FIRST_ADDR to LAST_ADDR and holds each code for DWELL cycles.
- Asserts a sample strobe once the decoder outputs have settled, so a downstream checker or consumer can capture Y.
- Supports start/stop control and a manual load of A while idle.

Parameters:
- DWELL, 3, cycles each address is held (>=1).
- FIRST_ADDR, 0, first scanned code (4 bits).
- LAST_ADDR, 15, last scanned code (4 bits). Must satisfy FIRST_ADDR <= LAST_ADDR.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  begin scan (level sampled each clk)
- stop  input  1  abort scan
- load  input  1  manual address load, honoured only in IDLE
- load_addr  input  4  value written to A on load
- A  output  4  registered decoder select
- busy  output  1  high while in RUN
- sample  output  1  one-cycle strobe on the last dwell cycle of each address
- done  output  1  one-cycle pulse at scan completion

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: A=FIRST_ADDR, busy=0, sample=0, done=0, state=IDLE, dwell_cnt=0. All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE:
  - A holds its value.
  - If start=1 and stop=0: next state RUN, A<=FIRST_ADDR, dwell_cnt<=0, busy<=1.
  - Else if load=1: A<=load_addr.
  - Priority in IDLE: stop > start > load.
- RUN:
  - dwell_cnt increments each cycle.
  - sample=1 in the cycle where dwell_cnt==DWELL-1.
  - At that point, if A!=LAST_ADDR: A<=A+1 and dwell_cnt<=0.
  - If A==LAST_ADDR: next state DONE.
  - start and load are ignored in RUN.
- stop in RUN:
  - Next state IDLE; busy<=0 next cycle.
  - No done pulse; A retains its current value.
  - A sample on that same cycle still occurs (the output is already registered).
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - A stays at LAST_ADDR.
  - start in DONE is ignored.
- Timing: start sampled at edge N → A=FIRST_ADDR and busy=1 from edge N+1. First sample is at edge N+DWELL. The full scan is (LAST-FIRST+1)*DWELL cycles of busy.
- A never exceeds LAST_ADDR. 4-bit arithmetic, so no overflow is possible for LAST_ADDR=15.
- dwell_cnt width is max(1, clog2(DWELL)).
- DWELL=1: sample is high on every RUN cycle and A increments every cycle.
- rst_n low mid-scan: immediate return to reset values, with no done pulse.

Optional Feature:
- Macro: SEQ_CONTINUOUS_EN.
- Defined:
  - At the end of LAST_ADDR's dwell, A<=FIRST_ADDR and the state stays RUN.
  - done pulses for one cycle coinciding with the wrap.
  - busy stays 1 until stop; only stop exits RUN, and DONE is unreachable.
- Undefined: single-shot scan as described above.

Test Plan:
- Reset with DWELL=3: hold rst_n=0, start pulse after release → A=0 at edge+1. A steps 0,1,…,15 every 3 cycles. sample fires 16 times. dwell4 Y matches 16'hFFFF with bit A cleared at each sample. done pulses once, 49 cycles after start. A=15 at end.
- load_addr=4'd9 with load=1 in IDLE → A=9 next cycle. Same test with start=1 simultaneously → A=0, busy=1 (start wins).
- stop asserted when A=5 → busy=0 next cycle, A stays 5, done never asserts. start with stop=1 in IDLE → stays IDLE.
- rst_n pulsed low asynchronously mid-scan at A=7 → A=0, busy=0, sample=0 immediately, without waiting for a clock edge.
- DWELL=1, FIRST_ADDR=2, LAST_ADDR=4 → A=2,3,4 on consecutive cycles. sample high for 3 cycles, then done high for 1 cycle.
- SEQ_CONTINUOUS_EN defined → after A=15 dwell, A=0 again with done pulse. Second pass is identical. stop → IDLE.
